// File: rtl/gray_stim_gen.sv
// gray_stim_gen: exhaustive Gray-code stimulus sweeper.
//
// Walks all 2^WIDTH input combinations in reflected Gray order, holding each
// vector for HOLD clocks, under a start/stop/done handshake. One-shot mode
// ends with a single-cycle done pulse. Continuous mode wraps back to the first
// index with a single-cycle wrap pulse and keeps sweeping until stopped.
//
// Optional build macro GRAY_STIM_DIR_EN adds a 'dir' input, latched with
// start. dir=1 sweeps from the top index down to 0. Without the macro the
// sweep always counts up and there is no dir port.
//
// All outputs are registered. vec is the Gray code of the next idx value, so
// vec and idx always change on the same edge.

module gray_stim_gen #(
    parameter int WIDTH = 3,
    parameter int HOLD  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
`ifdef GRAY_STIM_DIR_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] idx,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    // Hold counter width: enough to count 0..HOLD-1, never narrower than 1.
    localparam int               HCW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]   CNT_LAST = HCW'(HOLD - 1);
    localparam logic [HCW-1:0]   CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] IDX_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] IDX_ZERO = '0;
    localparam logic [WIDTH-1:0] IDX_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HCW-1:0]   r_cnt;
    logic [HCW-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0] r_idx;
    logic [WIDTH-1:0] w_idx_nxt;
    logic [WIDTH-1:0] r_vec;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_dir;
    logic             w_dir_nxt;

    // Direction requested at start time, and the sweep's current direction.
    logic             w_dir_in;
    logic             w_hold_exp;
    logic             w_at_end;
    logic [WIDTH-1:0] w_idx_first;
    logic [WIDTH-1:0] w_idx_start;

    // Reflected binary Gray code of a binary index.
    function automatic logic [WIDTH-1:0] f_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef GRAY_STIM_DIR_EN
    assign w_dir_in = dir;
`else
    assign w_dir_in = 1'b0;
`endif

    // Counter has spent HOLD cycles on the current index.
    assign w_hold_exp  = (r_cnt == CNT_LAST);
    // Last index of the sweep depends on the latched direction.
    assign w_at_end    = r_dir ? (r_idx == IDX_ZERO) : (r_idx == IDX_LAST);
    // First index of the running sweep (wrap target in continuous mode).
    assign w_idx_first = r_dir ? IDX_LAST : IDX_ZERO;
    // First index of a sweep about to be launched from IDLE.
    assign w_idx_start = w_dir_in ? IDX_LAST : IDX_ZERO;

    // Next-state and next-output decode; every target defaults to hold.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;

        case (r_state)
            S_IDLE: begin
                // stop wins over a coincident start.
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                    w_mode_nxt  = mode;
                    w_dir_nxt   = w_dir_in;
                    w_idx_nxt   = w_idx_start;
                    w_cnt_nxt   = CNT_ZERO;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_RUN: begin
                if (stop) begin
                    // Abort: idx/vec keep their values, no done or wrap.
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (w_hold_exp) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_at_end) begin
                        if (r_mode) begin
                            w_idx_nxt  = w_idx_first;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            // One-shot finish: last vector stays on the bus.
                            w_state_nxt = S_FIN;
                            w_valid_nxt = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else if (r_dir) begin
                        w_idx_nxt = r_idx - IDX_ONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + HCW'(1);
                end
            end

            S_FIN: begin
                // One cycle to drop done; start here is deliberately ignored.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; vec is re-encoded from the next idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_idx   <= IDX_ZERO;
            r_vec   <= IDX_ZERO;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_mode  <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_vec   <= f_gray(w_idx_nxt);
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
            r_mode  <= w_mode_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign vec   = r_vec;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_gray_stim_gen.sv
// Testbench for gray_stim_gen (WIDTH=3, HOLD=2): directed scenarios with
// literal expectations, then randomized start/stop/mode/reset traffic checked
// every cycle against a sweep-time model of the generator.
`timescale 1ns/1ps

module tb_gray_stim_gen;

    localparam int W = 3;
    localparam int H = 2;
    localparam int N = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic         mode  = 1'b0;
`ifdef GRAY_STIM_DIR_EN
    logic         dir   = 1'b0;
`endif
    logic [W-1:0] vec;
    logic [W-1:0] idx;
    logic         valid;
    logic         busy;
    logic         done;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gray_stim_gen #(.WIDTH(W), .HOLD(H)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
`ifdef GRAY_STIM_DIR_EN
        .dir   (dir),
`endif
        .vec   (vec),
        .idx   (idx),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is a span of N*H cycles; the index is elapsed time / H.
    bit m_active = 1'b0;
    bit m_fin    = 1'b0;
    bit m_mode   = 1'b0;
    bit m_dir    = 1'b0;
    bit e_done   = 1'b0;
    bit e_wrap   = 1'b0;
    int m_p      = 0;
    int e_idx    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_fin    = 1'b0;
            m_mode   = 1'b0;
            m_dir    = 1'b0;
            e_done   = 1'b0;
            e_wrap   = 1'b0;
            m_p      = 0;
            e_idx    = 0;
        end else begin
            e_done = 1'b0;
            e_wrap = 1'b0;
            if (m_fin) begin
                m_fin = 1'b0;
            end else if (!m_active) begin
                if (start && !stop) begin
                    m_active = 1'b1;
                    m_p      = 0;
                    m_mode   = mode;
`ifdef GRAY_STIM_DIR_EN
                    m_dir    = dir;
`endif
                end
            end else if (stop) begin
                m_active = 1'b0;
            end else begin
                m_p++;
                if (m_p == N * H) begin
                    if (m_mode) begin
                        m_p    = 0;
                        e_wrap = 1'b1;
                    end else begin
                        m_active = 1'b0;
                        m_fin    = 1'b1;
                        e_done   = 1'b1;
                    end
                end
            end
            if (m_active)
                e_idx = m_dir ? (N - 1 - m_p / H) : (m_p / H);
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_idx",   32'(idx),   32'(e_idx));
            chk("m_vec",   32'(vec),   32'(e_idx ^ (e_idx >> 1)));
            chk("m_valid", 32'(valid), 32'(m_active));
            chk("m_busy",  32'(busy),  32'(m_active));
            chk("m_done",  32'(done),  32'(e_done));
            chk("m_wrap",  32'(wrap),  32'(e_wrap));
        end
    end

    task automatic wait_idx(input int v);
        int n;
        n = 0;
        while (idx !== W'(v) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idx", 32'(idx), 32'(v));
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_up [8];
        int seq_dn [8];
        int n;
        seq_up = '{0, 1, 3, 2, 6, 7, 5, 4};
        seq_dn = '{4, 5, 7, 6, 2, 3, 1, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vec",   32'(vec),   0);
        chk("rst_idx",   32'(idx),   0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("rst_wrap",  32'(wrap),  0);

        // One-shot sweep, each vector held two cycles.
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("os_vec",   32'(vec),   32'(seq_up[i / 2]));
            chk("os_valid", 32'(valid), 1);
            @(negedge clk);
        end
        chk("os_done",     32'(done),  1);
        chk("os_busy",     32'(busy),  0);
        chk("os_valid_lo", 32'(valid), 0);
        chk("os_last_vec", 32'(vec),   4);
        @(negedge clk);
        chk("os_done_clr", 32'(done),  0);
        chk("os_last_vec2", 32'(vec),  4);

        // Continuous: wrap every 16 cycles after RUN entry, never done.
        pulse_start(1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("ct_wrap", 32'(wrap), 32'(c % 16 == 0));
            chk("ct_done", 32'(done), 0);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("ct_stop_busy", 32'(busy), 0);

        // Abort at idx 4.
        pulse_start(1'b0);
        wait_idx(4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("ab_valid", 32'(valid), 0);
        chk("ab_busy",  32'(busy),  0);
        chk("ab_done",  32'(done),  0);
        chk("ab_vec",   32'(vec),   6);
        chk("ab_idx",   32'(idx),   4);
        @(negedge clk);
        chk("ab_done2", 32'(done),  0);
        chk("ab_vec2",  32'(vec),   6);

        // Restart from 0; a start (with mode=1) while busy must be ignored.
        pulse_start(1'b0);
        chk("rs_idx",   32'(idx),   0);
        chk("rs_valid", 32'(valid), 1);
        wait_idx(2);
        pulse_start(1'b1);
        chk("bs_busy", 32'(busy), 1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bs_done", 32'(done), 1);
        @(negedge clk);

        // start and stop together in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy",  32'(busy),  0);
        chk("ss_valid", 32'(valid), 0);
        @(negedge clk);
        chk("ss_busy2", 32'(busy),  0);

`ifdef GRAY_STIM_DIR_EN
        // Down-counting one-shot sweep.
        dir = 1'b1;
        pulse_start(1'b0);
        dir = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("dn_vec", 32'(vec), 32'(seq_dn[i / 2]));
            @(negedge clk);
        end
        chk("dn_done", 32'(done), 1);
        @(negedge clk);
`endif

        // Asynchronous reset between edges at idx 5.
        pulse_start(1'b1);
        wait_idx(5);
        #2 rst = 1'b1;
        #1;
        chk("ar_vec",   32'(vec),   0);
        chk("ar_idx",   32'(idx),   0);
        chk("ar_valid", 32'(valid), 0);
        chk("ar_busy",  32'(busy),  0);
        chk("ar_done",  32'(done),  0);
        chk("ar_wrap",  32'(wrap),  0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_idle_busy", 32'(busy), 0);
            chk("ar_idle_vec",  32'(vec),  0);
        end

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            mode  = $urandom_range(0, 1);
`ifdef GRAY_STIM_DIR_EN
            dir   = $urandom_range(0, 1);
`endif
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
